if_fetch: RTL
=============

// Module: if_fetch
// PURPOSE
//  IF stage of the RV64 5-stage pipeline. Owns the fetch PC, runs a req/gnt/rvalid handshake to the 64-bit
//  instruction memory (one outstanding request), and buffers one 8-byte line (two instructions).
//  Presents pc/pc_valid/csr_vec_h to ID, and drives inst_sram_rdata registered one cycle behind the pc ID latched.
//  Handles branch/trap redirects, discarding stale responses in flight.
// PARAMETERS
//  RESET_PC   64'h8000_0000   fetch PC loaded on reset
//  CSRH_W     32              width of csr_vec_h (upper half of the 64-bit csr_vec)
// PORTS
//  clk              in   1       clock
//  rst              in   1       synchronous reset, active-high
//  flush            in   1       trap/xret redirect to new_pc; highest priority after rst
//  new_pc           in   64      flush target
//  br_e             in   1       branch/jump redirect from EX
//  br_addr          in   64      branch target
//  stall            in   6       pipeline stall vector; bit1=1 means ID does not accept this cycle
//  inst_req         out  1       memory request valid
//  inst_addr        out  64      request address, always {fpc[63:3],3'b0}
//  inst_gnt         in   1       request accepted (handshake = inst_req & inst_gnt)
//  inst_rvalid      in   1       response valid, >=1 cycle after gnt, exactly one per gnt
//  inst_rdata       in   64      response line
//  inst_err         in   1       access fault, qualified by inst_rvalid
//  pc_valid         out  1       pc/csr_vec_h hold a fetched instruction for ID
//  pc               out  64      PC of presented instruction
//  csr_vec_h        out  CSRH_W  bit0 = inst addr misaligned, bit1 = inst access fault, others 0
//  inst_sram_rdata  out  64      line of the pc ID latched last accepting edge
// BEHAVIOUR
//  Reset: state=REQ, fpc=RESET_PC, buffer invalid, pc_valid=0, inst_req=0 during rst, inst_sram_rdata=0, csr_vec_h=0.
//  Redirect: flush ? new_pc : br_e ? br_addr; flush wins when both are high.
//   Redirect sets fpc to the target and drops the buffer. pc_valid is 0 the next cycle.
//  Consume: state==FULL & !stall[1] & no redirect. At that edge inst_sram_rdata <= buf_data and fpc <= fpc+4.
//   inst_sram_rdata otherwise holds its value.
//  States:
//   REQ  : inst_req=1.
//          gnt & !redirect -> WAIT; gnt & redirect -> DROP.
//          redirect without gnt -> REQ with the new address next cycle.
//          fpc[1:0]!=0 -> no request; FULL with err_mis=1, buf_data=0.
//   WAIT : rvalid -> FULL, capture inst_rdata and inst_err.
//          redirect & !rvalid -> DROP; redirect & rvalid -> REQ, response discarded.
//   DROP : wait for the stale rvalid, discard it -> REQ. Redirect here only updates fpc.
//   FULL : pc_valid=1, pc=fpc, csr_vec_h={..,buf_err,err_mis}.
//          On consume: fpc[2]==0 & !err -> stay FULL (second word of same line, no new request).
//          fpc[2]==1 & !err -> REQ. Err packet consumed -> STOP.
//   STOP : no requests, pc_valid=0, until a redirect -> REQ.
//  pc_valid=0 in every state except FULL; pc and csr_vec_h are don't-care (driven 0) when pc_valid=0.
//  inst_req is never asserted in WAIT/DROP: at most one outstanding request.
//  fpc+4 wraps modulo 2^64 with no special handling.
//  rst during WAIT/DROP: a late rvalid arriving in REQ (no outstanding gnt) is ignored; the memory is reset with the core.
// STRUCTURE
//  Shared header defines.v: state encodings (FS_REQ/WAIT/DROP/FULL/STOP), CSRH_MIS_BIT=0, CSRH_AFLT_BIT=1, RESET_PC default.
//  One sub-module, fetch_line_buf: line data/err/mis registers with capture/clear controls.
//  The FSM and fpc live in if_fetch.
// TESTING
//  1 Reset, gnt same cycle, rvalid 1 cycle later with data 64'hB_A, no stall:
//    pc 8000_0000 then 8000_0004 on consecutive cycles, one request only;
//    inst_sram_rdata = 64'hB_A on both following cycles.
//  2 stall[1]=1 for 3 cycles in FULL: pc, pc_valid and inst_sram_rdata stable; no new inst_req.
//  3 br_e with br_addr=8000_0100 while in WAIT, rvalid 2 cycles later:
//    that response is dropped, next inst_addr=8000_0100, pc_valid=0 until its rvalid.
//  4 Redirect and rvalid in the same cycle (WAIT): data discarded, REQ to the target next cycle.
//    Also flush+br_e together: new_pc wins.
//  5 br_addr=8000_0102: no request; pc_valid=1, csr_vec_h=32'h1; after consume, STOP with no inst_req until flush.
//  6 inst_err=1 on response: csr_vec_h=32'h2 with pc_valid=1. Random gnt/rvalid delays 0-5 cycles:
//    scoreboard sees the PC stream contiguous, with exactly one request per line.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// -----------------------------------------------------------------------------
// if_fetch_pkg
// Shared definitions for the instruction-fetch stage: FSM state encodings,
// csr_vec_h bit positions, the default reset PC and a line-address helper.
// -----------------------------------------------------------------------------
package if_fetch_pkg;

    typedef enum logic [2:0] {
        FS_REQ  = 3'd0,   // issue a request for the line holding fpc
        FS_WAIT = 3'd1,   // granted, waiting for the response
        FS_DROP = 3'd2,   // granted, but a redirect made the response stale
        FS_FULL = 3'd3,   // buffered instruction presented to ID
        FS_STOP = 3'd4    // faulting packet consumed, idle until redirect
    } fetch_state_t;

    localparam int          CSRH_MIS_BIT     = 0;
    localparam int          CSRH_AFLT_BIT    = 1;
    localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;

    // The memory is 64 bits wide, so requests always use the 8-byte aligned address.
    function automatic logic [63:0] line_addr(input logic [63:0] addr);
        return {addr[63:3], 3'b000};
    endfunction

endpackage

// File: rtl/if_fetch_line_buf.sv
// -----------------------------------------------------------------------------
// if_fetch_line_buf
// One-entry line buffer for the fetch stage: holds the 8-byte line plus the
// access-fault and misaligned flags that travel with it.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   i_clr            drop the buffered line (redirect); wins over i_cap
//   i_cap            load i_data / i_err / i_mis
//   i_data, i_err, i_mis   values to load
//   o_data, o_err, o_mis   buffered values
// -----------------------------------------------------------------------------
module if_fetch_line_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_cap,
    input  logic [63:0] i_data,
    input  logic        i_err,
    input  logic        i_mis,
    output logic [63:0] o_data,
    output logic        o_err,
    output logic        o_mis
);

    logic [63:0] r_data;
    logic        r_err;
    logic        r_mis;

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_data <= '0;
            r_err  <= 1'b0;
            r_mis  <= 1'b0;
        end else if (i_cap) begin
            r_data <= i_data;
            r_err  <= i_err;
            r_mis  <= i_mis;
        end
    end

    assign o_data = r_data;
    assign o_err  = r_err;
    assign o_mis  = r_mis;

endmodule

// File: rtl/if_fetch.sv
// -----------------------------------------------------------------------------
// if_fetch
// IF stage of the RV64 5-stage pipeline. Owns the fetch PC (fpc), fetches
// 64-bit lines from instruction memory with at most one request outstanding,
// and presents one instruction at a time to ID. Both words of a line are
// served from the buffer, so a new request is issued only after the upper
// word (fpc[2]==1) is consumed.
//
// Handshakes:
//   Memory request : a request transfers on an edge where inst_req & inst_gnt.
//                    inst_req/inst_addr are steady while waiting for a grant,
//                    except that a redirect retargets inst_addr.
//                    Each grant is answered by exactly one inst_rvalid, at least
//                    one cycle later; responses made stale by a redirect are dropped.
//   ID transfer    : an instruction transfers on an edge where pc_valid & !stall[1]
//                    and no redirect is present; inst_sram_rdata then carries that
//                    instruction's line from the next cycle on.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush, new_pc             trap/xret redirect (wins over br_e)
//   br_e, br_addr             branch/jump redirect from EX
//   stall[5:0]                pipeline stall vector; only bit 1 (ID hold) is used here
//   inst_req, inst_addr       memory request and its 8-byte aligned address
//   inst_gnt                  memory accepted the request
//   inst_rvalid, inst_rdata,
//   inst_err                  memory response line and access fault
//   pc_valid, pc, csr_vec_h   instruction presented to ID and its exception bits
//   inst_sram_rdata           line of the instruction ID last accepted
//   o_dbg_state               current FSM state (fetch_state_t encoding)
// -----------------------------------------------------------------------------
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CSRH_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [63:0]       new_pc,
    input  logic              br_e,
    input  logic [63:0]       br_addr,
    input  logic [5:0]        stall,
    output logic              inst_req,
    output logic [63:0]       inst_addr,
    input  logic              inst_gnt,
    input  logic              inst_rvalid,
    input  logic [63:0]       inst_rdata,
    input  logic              inst_err,
    output logic              pc_valid,
    output logic [63:0]       pc,
    output logic [CSRH_W-1:0] csr_vec_h,
    output logic [63:0]       inst_sram_rdata,
    output logic [2:0]        o_dbg_state
);

    fetch_state_t r_state;
    fetch_state_t w_next;
    logic [63:0]  r_fpc;
    logic [63:0]  r_sram_rdata;

    logic         w_redirect;
    logic [63:0]  w_target;
    logic         w_misaligned;
    logic         w_consume;

    logic         w_cap;
    logic [63:0]  w_cap_data;
    logic         w_cap_err;
    logic         w_cap_mis;
    logic [63:0]  w_buf_data;
    logic         w_buf_err;
    logic         w_buf_mis;

    // Stall bits other than ID's are meant for later stages.
    logic         w_unused_stall;
    assign w_unused_stall = ^{stall[5:2], stall[0]};

    assign w_redirect   = flush | br_e;
    assign w_target     = flush ? new_pc : br_addr;
    assign w_misaligned = (r_fpc[1:0] != 2'b00);
    assign w_consume    = (r_state == FS_FULL) && !stall[1] && !w_redirect;

    assign inst_addr       = line_addr(r_fpc);
    assign inst_sram_rdata = r_sram_rdata;
    assign o_dbg_state     = r_state;

    if_fetch_line_buf u_line_buf (
        .clk    (clk),
        .rst    (rst),
        .i_clr  (w_redirect),
        .i_cap  (w_cap),
        .i_data (w_cap_data),
        .i_err  (w_cap_err),
        .i_mis  (w_cap_mis),
        .o_data (w_buf_data),
        .o_err  (w_buf_err),
        .o_mis  (w_buf_mis)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= FS_REQ;
            r_fpc        <= RESET_PC;
            r_sram_rdata <= '0;
        end else begin
            r_state <= w_next;
            // A redirect retargets fpc in every state, including DROP and STOP.
            if (w_redirect) begin
                r_fpc <= w_target;
            end else if (w_consume) begin
                r_fpc        <= r_fpc + 64'd4;
                r_sram_rdata <= w_buf_data;
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cap      = 1'b0;
        w_cap_data = inst_rdata;
        w_cap_err  = inst_err;
        w_cap_mis  = 1'b0;
        inst_req   = 1'b0;
        pc_valid   = 1'b0;
        pc         = '0;
        csr_vec_h  = '0;

        case (r_state)
            FS_REQ: begin
                if (w_misaligned) begin
                    // Never reaches memory: present a synthetic faulting packet.
                    if (!w_redirect) begin
                        w_next     = FS_FULL;
                        w_cap      = 1'b1;
                        w_cap_data = '0;
                        w_cap_err  = 1'b0;
                        w_cap_mis  = 1'b1;
                    end
                end else begin
                    inst_req = !rst;
                    // A grant on the redirect edge still owes us a response.
                    if (inst_gnt) begin
                        w_next = w_redirect ? FS_DROP : FS_WAIT;
                    end
                end
            end
            FS_WAIT: begin
                if (inst_rvalid) begin
                    if (w_redirect) begin
                        w_next = FS_REQ;
                    end else begin
                        w_next = FS_FULL;
                        w_cap  = 1'b1;
                    end
                end else if (w_redirect) begin
                    w_next = FS_DROP;
                end
            end
            FS_DROP: begin
                if (inst_rvalid) begin
                    w_next = FS_REQ;
                end
            end
            FS_FULL: begin
                pc_valid                 = 1'b1;
                pc                       = r_fpc;
                csr_vec_h[CSRH_MIS_BIT]  = w_buf_mis;
                csr_vec_h[CSRH_AFLT_BIT] = w_buf_err;
                if (w_redirect) begin
                    w_next = FS_REQ;
                end else if (!stall[1]) begin
                    if (w_buf_err || w_buf_mis) begin
                        w_next = FS_STOP;
                    end else if (r_fpc[2]) begin
                        w_next = FS_REQ;
                    end
                end
            end
            FS_STOP: begin
                if (w_redirect) begin
                    w_next = FS_REQ;
                end
            end
            default: begin
                w_next = FS_REQ;
            end
        endcase
    end

endmodule
